ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit inside the EX stage, directly upstream of the memory stage. It computes one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU result over multiple cycles and asserts a stall request so the pipeline holds the instruction in EX. Its result is selected in place of the ALU output onto the `aluresult` field of the EX→M interface. One operation is in flight at a time, and there is no pipelining between operations.

---
 rtl/ex_muldiv_if.sv | 25 ++
 rtl/ex_muldiv.sv | 173 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// EX-stage handshake between the pipeline control and the iterative
// multiply/divide unit. The pipeline side is the master, the unit is the slave.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            stall_req;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, op_a, op_b, flush,
    input  stall_req, busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output stall_req, busy, done, result
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit in EX. It runs one operation at a time
// over 32 iterations, and holds the pipeline through stall_req until the
// result is ready.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; divide-by-zero/overflow resolved on accept
// S_RUN  | one shift-add or restoring-divide step per cycle, 32 steps
// S_FIX  | sign correction and result selection, result register written
// S_DONE | done pulse, stall released so the instruction moves on to M
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t            state, state_nx;
  logic [2:0]        fn;
  logic              neg_q;
  logic              neg_r;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   res_q;

  logic              accept;
  logic              a_signed, b_signed, sa, sb;
  logic              b_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic [CW-1:0]     bit_idx;
  logic [2*XLEN-1:0] acc_mul, acc_div, prod;
  logic [XLEN:0]     rem_sh, trial;
  logic              q_bit;
  logic [XLEN-1:0]   new_rem, quo_s, rem_s, fix_res;

  assign accept = (state == S_IDLE) && bus.start && !bus.flush;

  // Operand decode on accept: which operands are signed, magnitudes, and
  // the cases resolved without iterating.
  always_comb begin
    a_signed    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                  (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    b_signed    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                  (bus.funct3 == 3'b110);
    sa          = a_signed && bus.op_a[XLEN-1];
    sb          = b_signed && bus.op_b[XLEN-1];
    b_zero      = (bus.op_b == '0);
    div_ovf     = ((bus.funct3 == 3'b100) || (bus.funct3 == 3'b110)) &&
                  (bus.op_a == MIN_NEG) && (bus.op_b == '1);
    special     = bus.funct3[2] && (b_zero || div_ovf);
    special_res = '0;
    if (b_zero)
      special_res = bus.funct3[1] ? bus.op_a : '1;
    else if (div_ovf)
      special_res = bus.funct3[1] ? '0 : MIN_NEG;
  end

  // One iteration step: MSB-first shift-add for multiply, restoring step for
  // divide with the remainder in acc[hi] and the quotient shifting into acc[lo].
  always_comb begin
    bit_idx = ~cnt;
    acc_mul = {acc[2*XLEN-2:0], 1'b0} +
              (mag_b[bit_idx] ? {{XLEN{1'b0}}, mag_a} : '0);
    rem_sh  = {acc[2*XLEN-1:XLEN], mag_a[bit_idx]};
    trial   = rem_sh - {1'b0, mag_b};
    q_bit   = ~trial[XLEN];
    new_rem = q_bit ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
    acc_div = {new_rem, acc[XLEN-2:0], q_bit};
  end

  // Sign correction and final selection of product half, quotient or remainder.
  always_comb begin
    prod  = neg_q ? -acc : acc;
    quo_s = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_s = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (fn[2])
      fix_res = fn[1] ? rem_s : quo_s;
    else if (fn[1:0] == 2'b00)
      fix_res = prod[XLEN-1:0];
    else
      fix_res = prod[2*XLEN-1:XLEN];
  end

  // Next state and handshake outputs; flush overrides everything.
  always_comb begin
    state_nx      = state;
    bus.stall_req = 1'b0;
    bus.done      = 1'b0;
    bus.busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (accept) begin
          bus.stall_req = 1'b1;
          state_nx      = special ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        bus.stall_req = 1'b1;
        if (cnt == CW'(XLEN-1))
          state_nx = S_FIX;
      end
      S_FIX: begin
        bus.stall_req = 1'b1;
        state_nx      = S_DONE;
      end
      S_DONE: begin
        bus.done = !bus.flush;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (bus.flush)
      state_nx = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // Datapath registers: latch operands on accept, iterate in RUN, write result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fn    <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      mag_a <= '0;
      mag_b <= '0;
      acc   <= '0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            fn    <= bus.funct3;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            mag_a <= sa ? -bus.op_a : bus.op_a;
            mag_b <= sb ? -bus.op_b : bus.op_b;
            acc   <= '0;
            cnt   <= '0;
            if (special)
              res_q <= special_res;
          end
        end
        S_RUN: begin
          if (!bus.flush) begin
            acc <= fn[2] ? acc_div : acc_mul;
            cnt <= cnt + CW'(1);
          end
        end
        S_FIX: begin
          if (!bus.flush)
            res_q <= fix_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = res_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: hand-computed RV32M results, completion cycle,
// stall window, flush and asynchronous reset behaviour.
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  ex_muldiv_if #(.XLEN(32)) bus ();

  ex_muldiv #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Starts one operation in the cycle after the next rising edge (cycle 0),
  // samples every negedge and checks completion cycle, stall window and result.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_cyc);
    int          dc;
    logic        stall_ok;
    logic [31:0] res;
    dc       = -1;
    stall_ok = 1'b1;
    res      = 'x;
    @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    for (int c = 0; c < 60 && dc < 0; c++) begin
      @(negedge clk);
      if (c < exp_cyc && !bus.stall_req) stall_ok = 1'b0;
      if (c == exp_cyc && bus.stall_req) stall_ok = 1'b0;
      if (bus.done) begin
        dc  = c;
        res = bus.result;
      end
    end
    check_val({tag, " done_cycle"}, 64'(dc), 64'(exp_cyc));
    check_val({tag, " result"}, {32'h0, res}, {32'h0, exp_res});
    check_val({tag, " stall_window"}, {63'h0, stall_ok}, 64'h1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check_val({tag, " idle_after"}, {62'h0, bus.busy, bus.done}, 64'h0);
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.op_a   = 32'h0;
    bus.op_b   = 32'h0;
    bus.flush  = 1'b0;
    #12;
    check_val("reset busy", {63'h0, bus.busy}, 64'h0);
    check_val("reset done", {63'h0, bus.done}, 64'h0);
    check_val("reset stall", {63'h0, bus.stall_req}, 64'h0);
    check_val("reset result", {32'h0, bus.result}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op("mul 7*-3",      3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run_op("mulh min*min",  3'b001, 32'h80000000,  32'h80000000, 32'h40000000, 34);
    run_op("mulhu min*min", 3'b011, 32'h80000000,  32'h80000000, 32'h40000000, 34);
    run_op("mulhsu -1*ff",  3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    run_op("mulhu ff*ff",   3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_op("div -7/2",      3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 34);
    run_op("rem -7/2",      3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 34);
    run_op("div 7/-2",      3'b100, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 34);
    run_op("rem 7/-2",      3'b110, 32'd7,         32'hFFFFFFFE, 32'd1,        34);
    run_op("divu 100/7",    3'b101, 32'd100,       32'd7,        32'd14,       34);
    run_op("divu 5/0",      3'b101, 32'd5,         32'd0,        32'hFFFFFFFF, 1);
    run_op("remu 5/0",      3'b111, 32'd5,         32'd0,        32'd5,        1);
    run_op("div ovf",       3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem ovf",       3'b110, 32'h80000000,  32'hFFFFFFFF, 32'd0,        1);
    run_op("remu 100/7",    3'b111, 32'd100,       32'd7,        32'd2,        34);

    // Flush a DIV in cycle 10; the unit must be idle in cycle 11 with the
    // previous result (2) still visible.
    @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.funct3 = 3'b100;
    bus.op_a   = 32'hFFFFFFF9;
    bus.op_b   = 32'd2;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(negedge clk);
    check_val("flush c10 done", {63'h0, bus.done}, 64'h0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check_val("flush c11 busy", {63'h0, bus.busy}, 64'h0);
    check_val("flush c11 done", {63'h0, bus.done}, 64'h0);
    check_val("flush c11 result", {32'h0, bus.result}, 64'd2);
    run_op("mul after flush", 3'b000, 32'd6, 32'd7, 32'd42, 34);

    // Asynchronous reset in the middle of RUN.
    @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.funct3 = 3'b000;
    bus.op_a   = 32'd7;
    bus.op_b   = 32'd9;
    repeat (5) @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.start = 1'b0;
    #1;
    check_val("rst busy", {63'h0, bus.busy}, 64'h0);
    check_val("rst done", {63'h0, bus.done}, 64'h0);
    check_val("rst stall", {63'h0, bus.stall_req}, 64'h0);
    check_val("rst result", {32'h0, bus.result}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op("mul after rst", 3'b000, 32'd3, 32'd5, 32'd15, 34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
